// File: rtl/ov7670_capture_if.sv
// rtl/ov7670_capture_if.sv - camera input and frame-buffer write bundle for ov7670_capture
interface ov7670_capture_if;
  logic        CAP_EN;
  logic        CAM_PCLK;
  logic        CAM_VSYNC;
  logic        CAM_HREF;
  logic [7:0]  CAM_DATA;
  logic        WR_EN;
  logic [16:0] WR_ADDR;
  logic [15:0] WR_DATA;
  logic        FRAME_DONE;
  logic        BUSY;

  modport master (
    input  CAP_EN, CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_DATA,
    output WR_EN, WR_ADDR, WR_DATA, FRAME_DONE, BUSY
  );

  modport slave (
    output CAP_EN, CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_DATA,
    input  WR_EN, WR_ADDR, WR_DATA, FRAME_DONE, BUSY
  );
endinterface

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB565 byte-stream capture into a cropped frame buffer
module ov7670_capture #(
  parameter int X_SIZE     = 240,
  parameter int Y_SIZE     = 320,
  parameter int FRAME_SKIP = 10
) (
  input  logic CLK_40M,
  input  logic RST,
  ov7670_capture_if.master bus
);
  localparam int XW  = $clog2(X_SIZE + 1);
  localparam int YW  = $clog2(Y_SIZE + 1);
  localparam int SKW = $clog2(FRAME_SKIP + 2);

  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE} state_t;

  state_t state, next_state;

  logic [1:0] pclk_s, vsync_s, href_s;
  logic [7:0] data_s1, data_s2;
  logic       pclk_d, vsync_d, href_d;
  logic       s, v_rise, h_fall;

  logic [SKW-1:0] skip_cnt;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic           phase;
  logic [7:0]     hi;
  logic           wr_en, frame_done, busy;
  logic [16:0]    wr_addr;
  logic [15:0]    wr_data;

  // All four camera inputs see the same two-stage delay so PCLK edges line up with data.
  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      pclk_s  <= '0;
      vsync_s <= '0;
      href_s  <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
      pclk_d  <= 1'b0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      pclk_s  <= {pclk_s[0], bus.CAM_PCLK};
      vsync_s <= {vsync_s[0], bus.CAM_VSYNC};
      href_s  <= {href_s[0], bus.CAM_HREF};
      data_s1 <= bus.CAM_DATA;
      data_s2 <= data_s1;
      pclk_d  <= pclk_s[1];
      vsync_d <= vsync_s[1];
      href_d  <= href_s[1];
    end
  end

  assign s      = pclk_s[1] & ~pclk_d;
  assign v_rise = vsync_s[1] & ~vsync_d;
  assign h_fall = ~href_s[1] & href_d;

  always_ff @(posedge CLK_40M) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.CAP_EN) next_state = SKIP;
      SKIP: begin
        if (!bus.CAP_EN)
          next_state = IDLE;
        else if (v_rise && skip_cnt == SKW'(FRAME_SKIP))
          next_state = CAPTURE;
      end
      CAPTURE: if (v_rise && !bus.CAP_EN) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state == CAPTURE) busy = 1'b1;
  end

  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      skip_cnt   <= '0;
      x          <= '0;
      y          <= '0;
      phase      <= 1'b0;
      hi         <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (bus.CAP_EN) skip_cnt <= '0;
        SKIP: begin
          if (bus.CAP_EN && v_rise) begin
            if (skip_cnt == SKW'(FRAME_SKIP)) begin
              x     <= '0;
              y     <= '0;
              phase <= 1'b0;
            end else begin
              skip_cnt <= skip_cnt + SKW'(1);
            end
          end
        end
        CAPTURE: begin
          if (v_rise) begin
            frame_done <= 1'b1;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
          end else if (h_fall) begin
            // Lines with no complete pixel do not consume a frame-buffer row.
            if (x != '0 && y != YW'(Y_SIZE)) y <= y + YW'(1);
            x     <= '0;
            phase <= 1'b0;
          end else if (s && href_s[1]) begin
            if (!phase) begin
              hi    <= data_s2;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (x != XW'(X_SIZE)) x <= x + XW'(1);
              if (x < XW'(X_SIZE) && y < YW'(Y_SIZE)) begin
                wr_en   <= 1'b1;
                wr_addr <= 17'(y) * 17'(X_SIZE) + 17'(x);
                wr_data <= {hi, data_s2};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.WR_EN      = wr_en;
  assign bus.WR_ADDR    = wr_addr;
  assign bus.WR_DATA    = wr_data;
  assign bus.FRAME_DONE = frame_done;
  assign bus.BUSY       = busy;
endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - randomized scoreboard bench for ov7670_capture
module tb_ov7670_capture;
  localparam int XS   = 8;
  localparam int YS   = 6;
  localparam int FS   = 2;
  localparam int HALF = 4;

  typedef struct {int addr; int data;} wr_t;
  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ov7670_capture_if cam_bus();

  ov7670_capture #(.X_SIZE(XS), .Y_SIZE(YS), .FRAME_SKIP(FS)) dut (
    .CLK_40M(clk),
    .RST(rst),
    .bus(cam_bus)
  );

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   fd_cnt  = 0;
  logic prev_wr = 1'b0;
  wr_t  exp_q[$];
  wr_t  obs_q[$];

  task automatic expect_eq(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cam_bus.WR_EN === 1'b1) begin
      expect_eq("wr_only_when_busy", int'(cam_bus.BUSY), 1);
      expect_eq("wr_one_cycle", int'(prev_wr), 0);
      obs_q.push_back('{int'(cam_bus.WR_ADDR), int'(cam_bus.WR_DATA)});
    end
    if (cam_bus.FRAME_DONE === 1'b1) fd_cnt++;
    prev_wr = cam_bus.WR_EN;
  end

  task automatic check_zero(input string tag);
    expect_eq({tag, "_wr_en"}, int'(cam_bus.WR_EN), 0);
    expect_eq({tag, "_wr_addr"}, int'(cam_bus.WR_ADDR), 0);
    expect_eq({tag, "_wr_data"}, int'(cam_bus.WR_DATA), 0);
    expect_eq({tag, "_frame_done"}, int'(cam_bus.FRAME_DONE), 0);
    expect_eq({tag, "_busy"}, int'(cam_bus.BUSY), 0);
  endtask

  task automatic pclk_tick(input logic [7:0] b, input logic href, input logic vs);
    cam_bus.CAM_PCLK  = 1'b0;
    cam_bus.CAM_DATA  = b;
    cam_bus.CAM_HREF  = href;
    cam_bus.CAM_VSYNC = vs;
    repeat (HALF) @(negedge clk);
    cam_bus.CAM_PCLK = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_vsync();
    repeat (3) pclk_tick(8'h00, 1'b0, 1'b1);
    repeat (2) pclk_tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_line(input bytes_t bq);
    foreach (bq[i]) pclk_tick(bq[i], 1'b1, 1'b0);
    repeat (2) pclk_tick(8'h00, 1'b0, 1'b0);
  endtask

  // Frame-buffer contents a line should produce: pairs form pixels, stray byte ignored,
  // columns beyond XS and rows beyond YS cropped, pixel-less lines keep the row.
  task automatic model_line(input bytes_t bq, inout int row);
    int npix;
    npix = bq.size() / 2;
    for (int p = 0; p < npix; p++)
      if (p < XS && row < YS)
        exp_q.push_back('{row * XS + p, {16'h0, bq[2*p], bq[2*p+1]}});
    if (npix > 0) row++;
  endtask

  task automatic send_frame(input bit cap, input bit force_pat, input bit drop_en);
    int nl, nb, row;
    bytes_t bq;
    send_vsync();
    row = 0;
    nl  = force_pat ? YS + 3 : int'($urandom_range(2, YS + 3));
    for (int li = 0; li < nl; li++) begin
      bq.delete();
      if (force_pat && li == 0) begin
        bq = '{8'hF8, 8'h00, 8'h07, 8'hE0};
      end else begin
        if (force_pat && li == 1)      nb = 2 * XS + 6;
        else if (force_pat && li == 2) nb = 5;
        else nb = int'($urandom_range(force_pat ? 2 : 0, 2 * XS + 7));
        for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
      end
      if (cap) model_line(bq, row);
      send_line(bq);
      if (drop_en && li == 1) cam_bus.CAP_EN = 1'b0;
    end
  endtask

  task automatic flush_compare(input string tag);
    int n;
    expect_eq({tag, "_write_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      expect_eq({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      expect_eq({tag, "_data"}, obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    bytes_t part;
    rst               = 1'b1;
    cam_bus.CAP_EN    = 1'b0;
    cam_bus.CAM_PCLK  = 1'b0;
    cam_bus.CAM_VSYNC = 1'b0;
    cam_bus.CAM_HREF  = 1'b0;
    cam_bus.CAM_DATA  = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    cam_bus.CAP_EN = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(1'b0, 1'b0, 1'b0);
    expect_eq("skip1_busy", int'(cam_bus.BUSY), 0);
    send_frame(1'b0, 1'b0, 1'b0);
    expect_eq("skip2_busy", int'(cam_bus.BUSY), 0);
    expect_eq("skip_writes", obs_q.size(), 0);
    send_frame(1'b1, 1'b1, 1'b0);
    expect_eq("capture_busy", int'(cam_bus.BUSY), 1);
    expect_eq("no_done_first_frame", fd_cnt, 0);
    if (obs_q.size() >= 2) begin
      expect_eq("first_addr", obs_q[0].addr, 0);
      expect_eq("first_data", obs_q[0].data, 32'hF800);
      expect_eq("second_addr", obs_q[1].addr, 1);
      expect_eq("second_data", obs_q[1].data, 32'h07E0);
    end else begin
      expect_eq("first_pair_count", obs_q.size(), 2);
    end
    send_frame(1'b1, 1'b0, 1'b0);
    expect_eq("continuous_done", fd_cnt, 1);
    expect_eq("continuous_busy", int'(cam_bus.BUSY), 1);
    send_frame(1'b1, 1'b0, 1'b1);
    expect_eq("drop_en_still_busy", int'(cam_bus.BUSY), 1);
    send_vsync();
    expect_eq("drop_en_done", fd_cnt, 3);
    expect_eq("drop_en_idle", int'(cam_bus.BUSY), 0);
    flush_compare("run1");

    cam_bus.CAP_EN = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    send_frame(1'b1, 1'b0, 1'b0);
    send_vsync();
    expect_eq("run2_done", fd_cnt, 4);
    flush_compare("run2");

    for (int i = 0; i < 7; i++) pclk_tick(8'($urandom), 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midline_reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pclk_tick(8'($urandom), 1'b1, 1'b0);
    repeat (2) pclk_tick(8'h00, 1'b0, 1'b0);
    obs_q.delete();

    send_frame(1'b0, 1'b0, 1'b0);
    expect_eq("post_reset_skip1_busy", int'(cam_bus.BUSY), 0);
    send_frame(1'b0, 1'b0, 1'b0);
    expect_eq("post_reset_skip2_busy", int'(cam_bus.BUSY), 0);
    expect_eq("post_reset_skip_writes", obs_q.size(), 0);
    send_frame(1'b1, 1'b0, 1'b0);
    expect_eq("post_reset_busy", int'(cam_bus.BUSY), 1);
    cam_bus.CAP_EN = 1'b0;
    send_vsync();
    expect_eq("post_reset_done", fd_cnt, 5);
    expect_eq("post_reset_idle", int'(cam_bus.BUSY), 0);
    flush_compare("run3");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 The block SHALL have parameter X_SIZE, default 240: pixels per line stored to the frame buffer.
REQ-002 The block SHALL have parameter Y_SIZE, default 320: lines per frame stored.
REQ-003 The block SHALL have parameter FRAME_SKIP, default 10: whole camera frames discarded after capture is enabled, for sensor settling.
REQ-004 The block SHALL have port CLK_40M, input, 1 bit: the single system clock; all logic on rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port CAP_EN, input, 1 bit: capture enable.
REQ-007 The block SHALL have port CAM_PCLK, input, 1 bit: camera pixel clock, treated as data, frequency <= CLK_40M/4.
REQ-008 The block SHALL have port CAM_VSYNC, input, 1 bit: camera frame sync, active-high.
REQ-009 The block SHALL have port CAM_HREF, input, 1 bit: camera line-valid.
REQ-010 The block SHALL have port CAM_DATA, input, 8 bits: camera byte bus, RGB565, high byte first.
REQ-011 The block SHALL have port WR_EN, output, 1 bit: one-cycle frame-buffer write strobe.
REQ-012 The block SHALL have port WR_ADDR, output, 17 bits: frame-buffer word address, range 0..X_SIZE*Y_SIZE-1.
REQ-013 The block SHALL have port WR_DATA, output, 16 bits: RGB565 pixel, valid when WR_EN=1.
REQ-014 The block SHALL have port FRAME_DONE, output, 1 bit: one-cycle pulse at the end of each captured frame.
REQ-015 The block SHALL have port BUSY, output, 1 bit: high while in state CAPTURE.

Function
REQ-016 CAM_PCLK, CAM_VSYNC, CAM_HREF and CAM_DATA SHALL each pass through two flip-flop stages before use, with equal delay for all four.
REQ-017 The sample event S SHALL be one cycle wide, asserted when synced PCLK=1 and its previous value=0; V_RISE SHALL be a one-cycle rising edge of synced VSYNC; H_FALL SHALL be a one-cycle falling edge of synced HREF.
REQ-018 The state machine SHALL have states IDLE, SKIP and CAPTURE.
REQ-019 IDLE: when CAP_EN=1, the machine SHALL go to SKIP with skip_cnt cleared to 0.
REQ-020 SKIP: on V_RISE, if skip_cnt==FRAME_SKIP the machine SHALL go to CAPTURE, else skip_cnt SHALL increment; FRAME_SKIP=0 means the first V_RISE starts capture.
REQ-021 SKIP: if CAP_EN=0, the machine SHALL return to IDLE.
REQ-022 Entry to CAPTURE and every V_RISE SHALL clear the column counter x, the row counter y and the byte phase.
REQ-023 CAPTURE, on S with synced HREF=1 and phase 0: the synced byte SHALL be latched as the high byte and phase set to 1.
REQ-024 CAPTURE, on S with synced HREF=1 and phase 1: pixel = {high, current byte}, phase SHALL be set to 0, and x SHALL increment, saturating at X_SIZE.
REQ-025 When a pixel completes with x<X_SIZE and y<Y_SIZE (values before increment), the block SHALL, in the next cycle, drive WR_EN=1 for exactly one cycle, WR_ADDR=y*X_SIZE+x and WR_DATA=pixel; otherwise (cropped) WR_EN SHALL stay 0.
REQ-026 On H_FALL in CAPTURE: if x>0, y SHALL increment, saturating at Y_SIZE; x and phase SHALL clear; a pending odd high byte SHALL be discarded.
REQ-027 CAPTURE, on V_RISE: FRAME_DONE SHALL pulse for one cycle (next cycle); if CAP_EN=1, the machine SHALL stay in CAPTURE (continuous capture), else go to IDLE.
REQ-028 Deasserting CAP_EN mid-frame SHALL NOT abort the frame; the current frame SHALL complete up to the next V_RISE.
REQ-029 WR_EN SHALL never assert outside CAPTURE; WR_ADDR and WR_DATA SHALL hold their last values when WR_EN=0.
REQ-030 If a write and FRAME_DONE fall due in the same cycle, both SHALL assert.

Reset
REQ-031 RST=1 at a clock edge SHALL force state IDLE, clear all counters, sync stages and phase, and set WR_EN=0, WR_ADDR=0, WR_DATA=0, FRAME_DONE=0 and BUSY=0, including mid-frame.
REQ-032 After reset, no write SHALL occur until a full SKIP sequence completes.

Verification
REQ-033 FRAME_SKIP=2, CAP_EN=1, 4 VSYNC pulses -> BUSY rises after the 3rd V_RISE; first FRAME_DONE at the 4th V_RISE; no WR_EN before the 3rd.
REQ-034 One line of bytes 0xF8,0x00,0x07,0xE0 -> writes addr 0 data 0xF800, then addr 1 data 0x07E0, each WR_EN one cycle wide, one cycle after S.
REQ-035 Line of 300 pixels with X_SIZE=240 -> exactly 240 writes (addr 0..239); second line starts at addr 240.
REQ-036 330 lines per frame with Y_SIZE=320 -> last write addr 76799; no writes for lines 320..329; FRAME_DONE once.
REQ-037 Line with 5 bytes (odd) -> 2 writes; next line starts at x=0 with correct byte pairing.
REQ-038 RST pulsed mid-line during CAPTURE -> all outputs 0 next cycle; BUSY stays 0 until the skip sequence completes again.
